dom_zrand_gen: RTL and testbench

Fresh-randomness source for the DOM-masked AES S-box datapath. It keeps a 32-bit LFSR and delivers one word of SHARES*(SHARES-1) bits per accepted transfer. That word has exactly the width of the Z input of the shared GF(2^2)/GF(2^4) multiplier gadgets. The block handles seeding, warm-up, the valid/ready transfer to the gadget pipeline, and periodic reseed enforcement.

---
 rtl/dom_zrand_gen.sv | 127 ++++++++++++
 tb/tb_dom_zrand_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dom_zrand_gen.sv
// dom_zrand_gen: fresh-randomness source for the DOM-masked AES S-box.
// A 32-bit LFSR is seeded, warmed up, then delivers one RAND_W-bit Z word
// per valid/ready transfer, with optional forced reseed after RESEED_WORDS.
// Ports:
//   ClkxCI       - clock, rising edge
//   RstxRI       - synchronous active-high reset
//   SeedxDI      - 32-bit seed value
//   SeedValidxSI - seed offered
//   SeedReadyxSO - seed accepted this cycle (FSM in SEED)
//   SeedErrxSO   - one-cycle pulse after an all-zero seed was rejected
//   ZxDO         - random word for the gadget Z inputs
//   ZValidxSO    - ZxDO valid (FSM in RUN)
//   ZReadyxSI    - consumer takes ZxDO
module dom_zrand_gen #(
   parameter int SHARES       = 2,
   parameter int RAND_W       = SHARES * (SHARES - 1),
   parameter int WARMUP       = 4,
   parameter int RESEED_WORDS = 0
) (
   input  logic              ClkxCI,
   input  logic              RstxRI,
   input  logic [31:0]       SeedxDI,
   input  logic              SeedValidxSI,
   output logic              SeedReadyxSO,
   output logic              SeedErrxSO,
   output logic [RAND_W-1:0] ZxDO,
   output logic              ZValidxSO,
   input  logic              ZReadyxSI
);

   typedef enum logic [1:0] {
      ST_SEED = 2'd0,
      ST_WARM = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam logic [7:0]  WARMUP_W = 8'(WARMUP);
   localparam logic [31:0] RESEED_W = 32'(RESEED_WORDS);

   state_e      state_q, state_d;
   logic [31:0] s_q, s_d;
   logic [7:0]  warm_cnt_q, warm_cnt_d;
   logic [31:0] word_cnt_q, word_cnt_d;
   logic        seed_err_q, seed_err_d;

   logic [31:0] s_adv;
   logic [7:0]  warm_inc;
   logic [31:0] word_inc;

   // RAND_W LFSR steps unrolled into one combinational advance
   function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
      logic [31:0] t;
      t = s;
      for (int i = 0; i < RAND_W; i++) begin
         t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
      end
      return t;
   endfunction

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      warm_cnt_d = warm_cnt_q;
      word_cnt_d = word_cnt_q;
      seed_err_d = 1'b0;
      s_adv      = lfsr_adv(s_q);
      warm_inc   = warm_cnt_q + 8'd1;
      word_inc   = word_cnt_q + 32'd1;
      unique case (state_q)
         ST_SEED: begin
            if (SeedValidxSI) begin
               if (SeedxDI != 32'd0) begin
                  s_d        = SeedxDI;
                  word_cnt_d = 32'd0;
                  warm_cnt_d = 8'd0;
                  state_d    = (WARMUP > 0) ? ST_WARM : ST_RUN;
               end else begin
                  // zero seed would lock the LFSR at zero
                  seed_err_d = 1'b1;
               end
            end
         end
         ST_WARM: begin
            s_d        = s_adv;
            warm_cnt_d = warm_inc;
            if (warm_inc == WARMUP_W) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ZReadyxSI) begin
               s_d        = s_adv;
               word_cnt_d = word_inc;
               // advanced state is kept; only validity drops until reseed
               if (RESEED_WORDS > 0 && word_inc == RESEED_W) begin
                  state_d = ST_SEED;
               end
            end
         end
         default: begin
            state_d = ST_SEED;
         end
      endcase
   end

   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         state_q    <= ST_SEED;
         s_q        <= 32'd0;
         warm_cnt_q <= 8'd0;
         word_cnt_q <= 32'd0;
         seed_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         warm_cnt_q <= warm_cnt_d;
         word_cnt_q <= word_cnt_d;
         seed_err_q <= seed_err_d;
      end
   end

   assign SeedReadyxSO = (state_q == ST_SEED);
   assign ZValidxSO    = (state_q == ST_RUN);
   assign SeedErrxSO   = seed_err_q;
   assign ZxDO         = s_q[RAND_W-1:0];

endmodule

// File: tb/tb_dom_zrand_gen.sv
// tb_dom_zrand_gen: directed self-checking bench for dom_zrand_gen.
// Three instances share stimulus: plain, WARMUP=2, RESEED_WORDS=3.
module tb_dom_zrand_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] seed;
   logic        seed_valid;
   logic        zready;

   logic       sr0, se0, zv0;
   logic [1:0] z0;
   logic       sr2, se2, zv2;
   logic [1:0] z2;
   logic       srr, ser, zvr;
   logic [1:0] zr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dom_zrand_gen #(.SHARES(2), .WARMUP(0), .RESEED_WORDS(0)) dut0 (
      .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed),
      .SeedValidxSI(seed_valid), .SeedReadyxSO(sr0),
      .SeedErrxSO(se0), .ZxDO(z0), .ZValidxSO(zv0),
      .ZReadyxSI(zready)
   );

   dom_zrand_gen #(.SHARES(2), .WARMUP(2), .RESEED_WORDS(0)) dut2 (
      .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed),
      .SeedValidxSI(seed_valid), .SeedReadyxSO(sr2),
      .SeedErrxSO(se2), .ZxDO(z2), .ZValidxSO(zv2),
      .ZReadyxSI(zready)
   );

   dom_zrand_gen #(.SHARES(2), .WARMUP(0), .RESEED_WORDS(3)) dutr (
      .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed),
      .SeedValidxSI(seed_valid), .SeedReadyxSO(srr),
      .SeedErrxSO(ser), .ZxDO(zr), .ZValidxSO(zvr),
      .ZReadyxSI(zready)
   );

   task automatic do_reset();
      rst = 1'b1;
      seed_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_seed(input logic [31:0] v);
      seed = v;
      seed_valid = 1'b1;
      @(negedge clk);
      seed_valid = 1'b0;
   endtask

   task automatic test_reset();
      zready = 1'b0;
      seed = 32'd0;
      do_reset();
      checks++;
      if (sr0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_seed_ready got %b want 1", sr0);
      end
      checks++;
      if (zv0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_zvalid got %b want 0", zv0);
      end
      checks++;
      if (se0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_seed_err got %b want 0", se0);
      end
      checks++;
      if (z0 !== 2'b00) begin
         errors++;
         $display("FAIL reset_z got %b want 00", z0);
      end
   endtask

   task automatic test_stream();
      logic [1:0] exp [4];
      exp[0] = 2'b01;
      exp[1] = 2'b10;
      exp[2] = 2'b11;
      exp[3] = 2'b01;
      do_reset();
      zready = 1'b1;
      do_seed(32'h1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (zv0 !== 1'b1 || z0 !== exp[i]) begin
            errors++;
            $display("FAIL stream_word%0d got v=%b z=%b want v=1 z=%b",
                     i, zv0, z0, exp[i]);
         end
         checks++;
         if (sr0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_seed_ready%0d got %b want 0", i, sr0);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      zready = 1'b0;
      do_seed(32'h1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (zv0 !== 1'b1 || z0 !== 2'b01) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b z=%b want v=1 z=01",
                     i, zv0, z0);
         end
         @(negedge clk);
      end
      zready = 1'b1;
      @(negedge clk);
      checks++;
      if (z0 !== 2'b10) begin
         errors++;
         $display("FAIL bp_next1 got %b want 10", z0);
      end
      @(negedge clk);
      checks++;
      if (z0 !== 2'b11) begin
         errors++;
         $display("FAIL bp_next2 got %b want 11", z0);
      end
   endtask

   task automatic test_ignore_seed_in_run();
      do_reset();
      zready = 1'b0;
      do_seed(32'h1);
      seed = 32'd0;
      seed_valid = 1'b1;
      @(negedge clk);
      seed = 32'h2;
      @(negedge clk);
      seed_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (se0 !== 1'b0) begin
         errors++;
         $display("FAIL run_seed_err got %b want 0", se0);
      end
      checks++;
      if (zv0 !== 1'b1 || z0 !== 2'b01) begin
         errors++;
         $display("FAIL run_seed_ignored got v=%b z=%b want v=1 z=01",
                  zv0, z0);
      end
   endtask

   task automatic test_zero_seed();
      do_reset();
      zready = 1'b1;
      seed = 32'd0;
      seed_valid = 1'b1;
      @(negedge clk);
      seed_valid = 1'b0;
      checks++;
      if (se0 !== 1'b1) begin
         errors++;
         $display("FAIL zero_err_pulse got %b want 1", se0);
      end
      checks++;
      if (zv0 !== 1'b0 || sr0 !== 1'b1) begin
         errors++;
         $display("FAIL zero_stay_seed got v=%b rdy=%b want v=0 rdy=1",
                  zv0, sr0);
      end
      @(negedge clk);
      checks++;
      if (se0 !== 1'b0 || zv0 !== 1'b0) begin
         errors++;
         $display("FAIL zero_after got err=%b v=%b want err=0 v=0",
                  se0, zv0);
      end
      zready = 1'b0;
      do_seed(32'h1);
      checks++;
      if (zv0 !== 1'b1 || z0 !== 2'b01) begin
         errors++;
         $display("FAIL zero_then_seed got v=%b z=%b want v=1 z=01",
                  zv0, z0);
      end
   endtask

   task automatic test_warmup();
      do_reset();
      zready = 1'b1;
      do_seed(32'h1);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (zv2 !== 1'b0 || sr2 !== 1'b0) begin
            errors++;
            $display("FAIL warm_cyc%0d got v=%b rdy=%b want v=0 rdy=0",
                     i, zv2, sr2);
         end
         @(negedge clk);
      end
      checks++;
      if (zv2 !== 1'b1 || z2 !== 2'b11) begin
         errors++;
         $display("FAIL warm_first got v=%b z=%b want v=1 z=11", zv2, z2);
      end
      @(negedge clk);
      checks++;
      if (z2 !== 2'b01) begin
         errors++;
         $display("FAIL warm_second got %b want 01", z2);
      end
   endtask

   task automatic test_reseed();
      logic [1:0] exp [3];
      exp[0] = 2'b01;
      exp[1] = 2'b10;
      exp[2] = 2'b11;
      do_reset();
      zready = 1'b1;
      do_seed(32'h1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (zvr !== 1'b1 || zr !== exp[i]) begin
            errors++;
            $display("FAIL reseed_word%0d got v=%b z=%b want v=1 z=%b",
                     i, zvr, zr, exp[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (zvr !== 1'b0 || srr !== 1'b1) begin
         errors++;
         $display("FAIL reseed_stop got v=%b rdy=%b want v=0 rdy=1",
                  zvr, srr);
      end
      do_seed(32'h1);
      checks++;
      if (zvr !== 1'b1 || zr !== 2'b01) begin
         errors++;
         $display("FAIL reseed_restart got v=%b z=%b want v=1 z=01",
                  zvr, zr);
      end
      @(negedge clk);
      checks++;
      if (zr !== 2'b10) begin
         errors++;
         $display("FAIL reseed_restart2 got %b want 10", zr);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      zready = 1'b1;
      do_seed(32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (zv0 !== 1'b0 || sr0 !== 1'b1 || se0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got v=%b rdy=%b err=%b want 0 1 0",
                  zv0, sr0, se0);
      end
      checks++;
      if (zv2 !== 1'b0 || sr2 !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_warm got v=%b rdy=%b want 0 1",
                  zv2, sr2);
      end
      @(negedge clk);
      do_seed(32'h1);
      checks++;
      if (zv0 !== 1'b1 || z0 !== 2'b01) begin
         errors++;
         $display("FAIL mid_reset_reseed got v=%b z=%b want v=1 z=01",
                  zv0, z0);
      end
   endtask

   initial begin
      rst = 1'b1;
      seed = 32'd0;
      seed_valid = 1'b0;
      zready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_ignore_seed_in_run();
      test_zero_seed();
      test_warmup();
      test_reseed();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
